// File: rtl/pipelined_normalizer_pkg.sv
// Shared constants and the S1 stage record for pipelined_normalizer.
//
// Contents:
//   DEF_*      default parameter values of the normaliser
//   s1_rec_t   record latched by stage 1: leading-one index p, shift
//              direction, shift amount, adjusted exponent, raw significand
//
// The record widths follow the DEF_* constants. A top-level instance with a
// different IN_W or EXP_W needs these constants changed as well; a mismatch
// shows up as a width error where the record is filled.
package pipelined_normalizer_pkg;

  localparam int DEF_IN_W     = 50;
  localparam int DEF_HEADROOM = 3;
  localparam int DEF_OUT_W    = 27;
  localparam int DEF_EXP_W    = 10;
  localparam int DEF_EXP_MAX  = 255;
  localparam int DEF_P_W      = $clog2(DEF_IN_W);

  typedef struct packed {
    logic [DEF_P_W-1:0]   p;       // index of the leading one
    logic                 dir;     // 1 = right shift, 0 = left shift
    logic [DEF_P_W-1:0]   amount;  // shift distance (already denorm-limited)
    logic [DEF_EXP_W:0]   exp;     // adjusted exponent, signed, unclamped
    logic [DEF_IN_W-1:0]  sig;     // unnormalised significand
  } s1_rec_t;

endpackage

// File: rtl/pipelined_normalizer_lod.sv
// Leading-one detector.
//
// Ports:
//   vec    in   IN_W    vector to scan
//   idx    out  IDX_W   index of the most significant set bit (0 if none)
//   found  out  1       vec has at least one set bit
//
// Loop-based priority scan: later (higher) set bits overwrite earlier ones,
// so the final value is the highest set position.
module lead_one_detect #(
  parameter int IN_W  = 50,
  parameter int IDX_W = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipelined_normalizer.sv
// Two-stage pipelined significand normaliser with sticky bit and
// exponent adjust / denormal limit / overflow flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    upstream handshake
//   sig_in, exp_in        unnormalised significand, signed biased exponent
//   out_valid, out_ready  downstream handshake
//   sig_out, exp_out      normalised significand (LSB = sticky), exponent
//   zero, denorm, ovf     input-zero, exponent-limited, exponent-overflow
//
// Handshake: a beat moves across a boundary on a rising edge where the
// producer's valid and the consumer's ready are both high; valid and data
// are held unchanged until that edge.
//
// Stage 1 finds the leading one and decides direction, distance and the new
// exponent; stage 2 performs the shift, forms the sticky bit and the flags.
module pipelined_normalizer
  import pipelined_normalizer_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int HEADROOM = DEF_HEADROOM,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int EXP_W    = DEF_EXP_W,
  parameter int EXP_MAX  = DEF_EXP_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sig_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] sig_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             zero,
  output logic             denorm,
  output logic             ovf
);

  localparam int LEAD   = IN_W - 1 - HEADROOM;
  localparam int P_W    = $clog2(IN_W);
  localparam int WIN_LO = LEAD - OUT_W + 2;  // lowest input-aligned bit kept
  localparam int XW     = 2 * IN_W;
  localparam logic signed [EXP_W:0] ONE_X     = (EXP_W+1)'(1);
  localparam logic signed [EXP_W:0] EXP_MAX_X = (EXP_W+1)'(EXP_MAX);

  // ---------------- flow control ----------------
  logic s1_valid;
  logic s2_adv, s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // ---------------- stage 1: detect and plan ----------------
  logic [P_W-1:0] lod_idx;
  logic           lod_found;

  lead_one_detect #(.IN_W(IN_W), .IDX_W(P_W)) u_lod (
    .vec   (sig_in),
    .idx   (lod_idx),
    .found (lod_found)
  );

  s1_rec_t                 s1_d, s1_q;
  logic signed [EXP_W:0]   exp_x, left_exp;
  logic [P_W-1:0]          l_amt;

  always_comb begin
    s1_d     = '0;
    s1_d.p   = lod_idx;
    s1_d.sig = sig_in;
    exp_x    = {exp_in[EXP_W-1], exp_in};
    l_amt    = P_W'(LEAD) - lod_idx;  // only meaningful when p <= LEAD
    left_exp = exp_x - $signed({{(EXP_W+1-P_W){1'b0}}, l_amt});
    if (!lod_found) begin
      // zero input: no shift, exponent forced to 0 downstream
      s1_d.dir    = 1'b0;
      s1_d.amount = '0;
      s1_d.exp    = '0;
    end else if (lod_idx > P_W'(LEAD)) begin
      s1_d.dir    = 1'b1;
      s1_d.amount = lod_idx - P_W'(LEAD);
      s1_d.exp    = exp_x + $signed({{(EXP_W+1-P_W){1'b0}}, lod_idx - P_W'(LEAD)});
    end else begin
      s1_d.dir = 1'b0;
      s1_d.exp = left_exp;
      if (left_exp < ONE_X) begin
        // exponent would fall below 1: shift only as far as exponent 1
        // allows. Here exp_in < LEAD+1, so exp_in-1 fits in P_W bits.
        s1_d.amount = (exp_x > ONE_X) ? P_W'(exp_x - ONE_X) : '0;
      end else begin
        s1_d.amount = l_amt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // ---------------- stage 2: shift, sticky, flags ----------------
  logic [XW-1:0]         ext, shifted;
  logic [OUT_W-2:0]      win;
  logic                  sticky;
  logic signed [EXP_W:0] exp_q;
  logic                  is_zero, denorm_d, ovf_d;
  logic [EXP_W-1:0]      exp_d;
  logic [OUT_W-1:0]      sig_d;

  always_comb begin
    // Significand sits in the top half so right-shifted-out bits stay
    // visible in the bottom half and feed the sticky bit.
    ext     = {s1_q.sig, {IN_W{1'b0}}};
    shifted = s1_q.dir ? (ext >> s1_q.amount) : (ext << s1_q.amount);
    win     = shifted[IN_W+LEAD -: OUT_W-1];
    sticky  = (|shifted[XW-1:IN_W+LEAD+1]) | (|shifted[IN_W+WIN_LO-1:0]);
    exp_q   = $signed(s1_q.exp);
    // p is the leading-one index, so p==0 with bit 0 clear means all zero
    is_zero  = (s1_q.p == '0) && !s1_q.sig[0];
    denorm_d = !is_zero && !s1_q.dir && (exp_q < ONE_X);
    ovf_d    = !is_zero && s1_q.dir && (exp_q > EXP_MAX_X);
    exp_d    = (is_zero || denorm_d) ? '0 : exp_q[EXP_W-1:0];
    sig_d    = is_zero ? '0 : {win, sticky};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sig_out   <= '0;
      exp_out   <= '0;
      zero      <= 1'b0;
      denorm    <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sig_out <= sig_d;
        exp_out <= exp_d;
        zero    <= is_zero;
        denorm  <= denorm_d;
        ovf     <= ovf_d;
      end
    end
  end

endmodule
